// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: opcodes, decoder states and reset defaults shared by the command decoder
package cmd_decoder_pkg;
  typedef enum logic [2:0] {S_OPCODE, S_PIX, S_FONT, S_COL_HI, S_COL_LO} state_t;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LOAD_FONT = 8'h80;
  localparam logic [7:0] OP_PIXDATA = 8'h81;
  localparam logic [7:0] OP_SET_FG = 8'h82;
  localparam logic [7:0] OP_SET_BG = 8'h83;
  localparam int FONT_BYTES_DEF = 4096;
  localparam logic [11:0] FG_RESET = 12'hFF0;
  localparam logic [11:0] BG_RESET = 12'h208;
endpackage

// File: rtl/cmd_decoder.sv
// cmd_decoder: byte-stream command decoder driving font RAM writes, test pixel and colour registers
import cmd_decoder_pkg::*;
module cmd_decoder #(
  parameter int FONT_BYTES = FONT_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        has_data,
  input  logic [7:0]  rd_data,
  output logic        rd,
  output logic        font_we,
  output logic [11:0] font_addr,
  output logic [7:0]  font_data,
  output logic [7:0]  pixreg,
  output logic [11:0] fg_color,
  output logic [11:0] bg_color,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam logic [11:0] LAST = 12'(FONT_BYTES - 1);
  state_t state, state_n;
  logic [7:0] byte_q, pix_n, data_n, err_n;
  logic [11:0] addr_n, fg_n, bg_n;
  logic [3:0] red, red_n;
  logic tgt_bg, tgt_bg_n, we_n, accept;
  assign accept = has_data && !rd;
  always_comb begin
    state_n = state;
    pix_n = pixreg;
    data_n = font_data;
    err_n = err_count;
    fg_n = fg_color;
    bg_n = bg_color;
    red_n = red;
    tgt_bg_n = tgt_bg;
    we_n = 1'b0;
    addr_n = font_we ? (font_addr == LAST ? 12'd0 : font_addr + 12'd1) : font_addr;
    if (rd) begin
      case (state)
        S_OPCODE: begin
          if (byte_q == OP_LOAD_FONT) begin
            state_n = S_FONT;
            addr_n = 12'd0;
          end else if (byte_q == OP_PIXDATA) begin
            state_n = S_PIX;
          end else if (byte_q == OP_SET_FG || byte_q == OP_SET_BG) begin
            state_n = S_COL_HI;
            tgt_bg_n = byte_q[0];
          end else if (byte_q != OP_NOP) begin
            err_n = err_count == 8'hFF ? err_count : err_count + 8'd1;
          end
        end
        S_PIX: begin
          pix_n = byte_q;
          state_n = S_OPCODE;
        end
        S_FONT: begin
          we_n = 1'b1;
          data_n = byte_q;
          state_n = font_addr == LAST ? S_OPCODE : S_FONT;
        end
        S_COL_HI: begin
          red_n = byte_q[3:0];
          state_n = S_COL_LO;
        end
        S_COL_LO: begin
          fg_n = tgt_bg ? fg_color : {red, byte_q};
          bg_n = tgt_bg ? {red, byte_q} : bg_color;
          state_n = S_OPCODE;
        end
        default: state_n = S_OPCODE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OPCODE;
      rd <= 1'b0;
      byte_q <= 8'd0;
      font_we <= 1'b0;
      font_addr <= 12'd0;
      font_data <= 8'd0;
      pixreg <= 8'd0;
      fg_color <= FG_RESET;
      bg_color <= BG_RESET;
      busy <= 1'b0;
      err_count <= 8'd0;
      red <= 4'd0;
      tgt_bg <= 1'b0;
    end else begin
      rd <= accept;
      if (accept) byte_q <= rd_data;
      state <= state_n;
      font_we <= we_n;
      font_addr <= addr_n;
      font_data <= data_n;
      pixreg <= pix_n;
      fg_color <= fg_n;
      bg_color <= bg_n;
      busy <= state_n != S_OPCODE;
      err_count <= err_n;
      red <= red_n;
      tgt_bg <= tgt_bg_n;
    end
  end
endmodule
